// File: rtl/gate_occupancy.sv
// Gate occupancy front end: sensor-sequence FSM -> entry/exit events -> saturating car count.
// Latency: one edge from the final sampled 00 to the event pulse and new count (+2 with SENSOR_SYNC_EN).
// No backpressure: sensors are sampled every cycle; optional macro SENSOR_SYNC_EN adds 2-flop sensor synchronizers.
module gate_occupancy #(
  parameter int CAPACITY = 3,
  parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_outer,
  input  logic             sensor_inner,
  output logic [CNT_W-1:0] occupancy,
  output logic             slot_empty,
  output logic             slot_full,
  output logic             car_entered,
  output logic             car_exited,
  output logic             seq_error,
  output logic             count_error
);

  localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, ERR} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] code;
  logic       entry_evt;
  logic       exit_evt;
  logic       err_evt;

`ifdef SENSOR_SYNC_EN
  logic [1:0] sync_q1;
  logic [1:0] sync_q2;

  // Two-flop synchronizer per beam; cleared so a reset never replays stale beam state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 2'b00;
      sync_q2 <= 2'b00;
    end else begin
      sync_q1 <= {sensor_outer, sensor_inner};
      sync_q2 <= sync_q1;
    end
  end

  assign code = sync_q2;
`else
  assign code = {sensor_outer, sensor_inner};
`endif

  // State register; reset drops any partially observed car.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode from the {outer,inner} code; the final 00 of a full sequence raises an event.
  always_comb begin
    state_nxt = state;
    entry_evt = 1'b0;
    exit_evt  = 1'b0;
    case (state)
      IDLE: begin
        case (code)
          2'b00:   state_nxt = IDLE;
          2'b10:   state_nxt = IN1;
          2'b01:   state_nxt = OUT1;
          default: state_nxt = ERR;
        endcase
      end
      IN1: begin
        case (code)
          2'b10:   state_nxt = IN1;
          2'b11:   state_nxt = IN2;
          2'b00:   state_nxt = IDLE;
          default: state_nxt = ERR;
        endcase
      end
      IN2: begin
        case (code)
          2'b11:   state_nxt = IN2;
          2'b01:   state_nxt = IN3;
          2'b10:   state_nxt = IN1;
          default: state_nxt = ERR;
        endcase
      end
      IN3: begin
        case (code)
          2'b01:   state_nxt = IN3;
          2'b11:   state_nxt = IN2;
          2'b00: begin
            state_nxt = IDLE;
            entry_evt = 1'b1;
          end
          default: state_nxt = ERR;
        endcase
      end
      OUT1: begin
        case (code)
          2'b01:   state_nxt = OUT1;
          2'b11:   state_nxt = OUT2;
          2'b00:   state_nxt = IDLE;
          default: state_nxt = ERR;
        endcase
      end
      OUT2: begin
        case (code)
          2'b11:   state_nxt = OUT2;
          2'b10:   state_nxt = OUT3;
          2'b01:   state_nxt = OUT1;
          default: state_nxt = ERR;
        endcase
      end
      OUT3: begin
        case (code)
          2'b10:   state_nxt = OUT3;
          2'b11:   state_nxt = OUT2;
          2'b00: begin
            state_nxt = IDLE;
            exit_evt  = 1'b1;
          end
          default: state_nxt = ERR;
        endcase
      end
      ERR: begin
        state_nxt = (code == 2'b00) ? IDLE : ERR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // seq_error fires only on the way into ERR, never while parked there.
  assign err_evt = (state_nxt == ERR) && (state != ERR);

  // Registered count and event pulses; count saturates at both ends and flags the attempt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy   <= '0;
      car_entered <= 1'b0;
      car_exited  <= 1'b0;
      seq_error   <= 1'b0;
      count_error <= 1'b0;
    end else begin
      car_entered <= entry_evt;
      car_exited  <= exit_evt;
      seq_error   <= err_evt;
      count_error <= (entry_evt && (occupancy >= CAP_V)) ||
                     (exit_evt && (occupancy == '0));
      if (entry_evt && (occupancy < CAP_V)) begin
        occupancy <= occupancy + ONE_V;
      end else if (exit_evt && (occupancy != '0)) begin
        occupancy <= occupancy - ONE_V;
      end
    end
  end

  assign slot_empty = (occupancy == '0);
  assign slot_full  = (occupancy == CAP_V);

endmodule

// File: tb/tb_gate_occupancy.sv
// Bench for gate_occupancy: directed gate scenarios followed by randomized sensor traffic.
// Expected outputs come from a table-driven reference model and are queued per cycle.
// A negedge monitor pops one expectation per cycle and compares it to the DUT outputs.
module tb_gate_occupancy;

  localparam int CAP   = 3;
  localparam int CNT_W = 2;
`ifdef SENSOR_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             so;
  logic             si;
  logic [CNT_W-1:0] occupancy;
  logic             slot_empty;
  logic             slot_full;
  logic             car_entered;
  logic             car_exited;
  logic             seq_error;
  logic             count_error;

  gate_occupancy #(.CAPACITY(CAP)) dut (
    .clk          (clk),
    .reset        (reset),
    .sensor_outer (so),
    .sensor_inner (si),
    .occupancy    (occupancy),
    .slot_empty   (slot_empty),
    .slot_full    (slot_full),
    .car_entered  (car_entered),
    .car_exited   (car_exited),
    .seq_error    (seq_error),
    .count_error  (count_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0] occ;
    logic empty;
    logic full;
    logic ent;
    logic ext;
    logic serr;
    logic cerr;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: gate position 0..7 = idle, in1..in3, out1..out3, error; table indexed by {outer,inner}.
  int         nxt_tab[8][4];
  int         m_st;
  int         m_occ;
  logic [1:0] pipe0;
  logic [1:0] pipe1;
  exp_t       m_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st   = 0;
    m_occ  = 0;
    pipe0  = 2'b00;
    pipe1  = 2'b00;
    m_last = '0;
    m_last.empty = 1'b1;
  endtask

  task automatic model_edge(input logic [1:0] raw, output exp_t e);
    logic [1:0] s;
    int ns;
    if (SYNC) begin
      s     = pipe1;
      pipe1 = pipe0;
      pipe0 = raw;
    end else begin
      s = raw;
    end
    ns = nxt_tab[m_st][int'(s)];
    e = '0;
    e.ent  = (m_st == 3) && (s == 2'b00);
    e.ext  = (m_st == 6) && (s == 2'b00);
    e.serr = (ns == 7) && (m_st != 7);
    if (e.ent) begin
      if (m_occ < CAP) m_occ++;
      else e.cerr = 1'b1;
    end
    if (e.ext) begin
      if (m_occ > 0) m_occ--;
      else e.cerr = 1'b1;
    end
    m_st    = ns;
    e.occ   = CNT_W'(m_occ);
    e.empty = (m_occ == 0);
    e.full  = (m_occ == CAP);
    m_last  = e;
  endtask

  // One clock of stimulus: drive after the negedge, advance the model after the posedge.
  task automatic step(input logic [1:0] sv, input logic rv);
    exp_t e;
    @(negedge clk);
    #1;
    so = sv[1];
    si = sv[0];
    if (!rv && reset) begin
      reset = 1'b0;
      #1;
      chk("async_rst_occupancy", 32'(occupancy), 0);
      chk("async_rst_pulses", {car_entered, car_exited, seq_error, count_error}, 0);
    end
    reset = rv;
    @(posedge clk);
    #1;
    if (!rv) begin
      model_reset();
      e = m_last;
    end else begin
      model_edge(sv, e);
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 1'b1);
  endtask

  task automatic run_entry(input int hold);
    for (int i = 0; i < hold; i++) step(2'b10, 1'b1);
    for (int i = 0; i < hold; i++) step(2'b11, 1'b1);
    for (int i = 0; i < hold; i++) step(2'b01, 1'b1);
    idle(4);
  endtask

  task automatic run_exit(input int hold);
    for (int i = 0; i < hold; i++) step(2'b01, 1'b1);
    for (int i = 0; i < hold; i++) step(2'b11, 1'b1);
    for (int i = 0; i < hold; i++) step(2'b10, 1'b1);
    idle(4);
  endtask

  // Monitor: every cycle carries an output word, so one expectation is consumed per negedge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("occupancy",   32'(occupancy),   32'(e.occ));
      chk("slot_empty",  32'(slot_empty),  32'(e.empty));
      chk("slot_full",   32'(slot_full),   32'(e.full));
      chk("car_entered", 32'(car_entered), 32'(e.ent));
      chk("car_exited",  32'(car_exited),  32'(e.ext));
      chk("seq_error",   32'(seq_error),   32'(e.serr));
      chk("count_error", 32'(count_error), 32'(e.cerr));
    end
  end

  initial begin
    int fill_exp[4];
    int drain_exp[4];
    int kind;
    int n;
    fill_exp  = '{1, 2, 3, 3};
    drain_exp = '{2, 1, 0, 0};
    nxt_tab = '{'{0, 4, 1, 7},
                '{0, 7, 1, 2},
                '{7, 3, 1, 2},
                '{0, 3, 7, 2},
                '{0, 4, 7, 5},
                '{7, 4, 6, 5},
                '{0, 7, 6, 5},
                '{0, 7, 7, 7}};
    reset = 1'b0;
    so    = 1'b0;
    si    = 1'b0;
    model_reset();

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) step(2'b00, 1'b0);
    idle(2);
    chk("reset_occupancy", 32'(occupancy), 0);
    chk("reset_empty", 32'(slot_empty), 1);

    // Fill past capacity.
    for (int i = 0; i < 4; i++) begin
      run_entry(1);
      chk("fill_occupancy", 32'(occupancy), 32'(fill_exp[i]));
    end
    chk("fill_full", 32'(slot_full), 1);

    // Drain past empty.
    for (int i = 0; i < 4; i++) begin
      run_exit(1);
      chk("drain_occupancy", 32'(occupancy), 32'(drain_exp[i]));
    end
    chk("drain_empty", 32'(slot_empty), 1);

    // Abort: car backs out after reaching both beams.
    run_entry(2);
    step(2'b10, 1'b1);
    step(2'b11, 1'b1);
    step(2'b10, 1'b1);
    idle(4);
    chk("abort_occupancy", 32'(occupancy), 1);

    // Illegal jump, then error held until both beams clear.
    step(2'b10, 1'b1);
    step(2'b01, 1'b1);
    for (int i = 0; i < 4; i++) step(2'b01, 1'b1);
    idle(4);

    // Reset while the car sits across both beams, then finish the motion.
    step(2'b10, 1'b1);
    for (int i = 0; i < 3; i++) step(2'b11, 1'b1);
    step(2'b11, 1'b0);
    step(2'b11, 1'b1);
    step(2'b01, 1'b1);
    idle(4);
    chk("midseq_reset_occupancy", 32'(occupancy), 0);

    // Randomized traffic.
    for (int it = 0; it < 250; it++) begin
      kind = int'($urandom_range(0, 11));
      if (kind <= 4) begin
        run_entry(int'($urandom_range(1, 3)));
      end else if (kind <= 7) begin
        run_exit(int'($urandom_range(1, 3)));
      end else if (kind <= 10) begin
        n = int'($urandom_range(1, 5));
        for (int j = 0; j < n; j++) step(2'($urandom_range(0, 3)), 1'b1);
      end else if ($urandom_range(0, 2) == 0) begin
        step(2'($urandom_range(0, 3)), 1'b0);
      end else begin
        idle(1);
      end
    end

    idle(4);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
